// File: rtl/thread_regfile.sv
// Per-lane register file: R0-R12 general purpose, R13 mirrors block_id,
// R14/R15 are read-only blockDim/threadIdx. Operands latch in REQUEST, results commit in UPDATE.
module thread_regfile #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [7:0]           decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic                 illegal_write
);

    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam int         NUM_GPR    = 13;
    localparam logic [3:0] LAST_GPR   = 4'd12;

    localparam logic [DATA_BITS-1:0] BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX = DATA_BITS'(THREAD_ID);

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_LSU = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    logic [DATA_BITS-1:0] gpr_q [NUM_GPR];
    logic [DATA_BITS-1:0] gpr_d [NUM_GPR];
    logic [DATA_BITS-1:0] r13_q, r13_d;
    logic [DATA_BITS-1:0] rs_q, rs_d;
    logic [DATA_BITS-1:0] rt_q, rt_d;
    logic                 illegal_q, illegal_d;

    logic [DATA_BITS-1:0] rf_view [16];
    logic [DATA_BITS-1:0] wb_data;
    logic                 wb_src_ok;
    logic                 wb_req;

    // Full 16-entry architectural view used by both read ports.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            rf_view[i] = gpr_q[i];
        end
        rf_view[13] = r13_q;
        rf_view[14] = BLOCK_DIM;
        rf_view[15] = THREAD_IDX;
    end

    always_comb begin
        wb_data   = '0;
        wb_src_ok = 1'b1;
        case (decoded_reg_input_mux)
            MUX_ALU: wb_data = alu_out;
            MUX_LSU: wb_data = lsu_out;
            MUX_IMM: wb_data = DATA_BITS'(decoded_immediate);
            default: wb_src_ok = 1'b0;
        endcase
    end

    assign wb_req = enable && (core_state == ST_UPDATE) && decoded_reg_write_enable;

    always_comb begin
        gpr_d     = gpr_q;
        r13_d     = r13_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        illegal_d = illegal_q;

        if (enable) begin
            r13_d = DATA_BITS'(block_id);
            if (core_state == ST_REQUEST) begin
                rs_d = rf_view[decoded_rs_address];
                rt_d = rf_view[decoded_rt_address];
            end
        end

        // A reserved source or a protected destination flags the write instead of performing it.
        if (wb_req) begin
            if (!wb_src_ok || (decoded_rd_address > LAST_GPR)) begin
                illegal_d = 1'b1;
            end else begin
                gpr_d[decoded_rd_address] = wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            r13_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            gpr_q     <= gpr_d;
            r13_q     <= r13_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            illegal_q <= illegal_d;
        end
    end

    assign rs            = rs_q;
    assign rt            = rt_q;
    assign illegal_write = illegal_q;

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: expected operands are queued when a REQUEST
// is driven and popped when the registered outputs appear.
module tb_thread_regfile;

    localparam int TPB = 4;
    localparam int TID = 2;
    localparam int DB  = 8;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    block_id;
    logic [2:0]    core_state;
    logic [3:0]    rd_a, rs_a, rt_a;
    logic          we;
    logic [1:0]    mux;
    logic [7:0]    imm;
    logic [DB-1:0] alu_out, lsu_out;
    logic [DB-1:0] rs, rt;
    logic          illegal_write;

    typedef struct {
        string         tag;
        logic [DB-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    thread_regfile #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .block_id(block_id),
        .core_state(core_state),
        .decoded_rd_address(rd_a),
        .decoded_rs_address(rs_a),
        .decoded_rt_address(rt_a),
        .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux),
        .decoded_immediate(imm),
        .alu_out(alu_out),
        .lsu_out(lsu_out),
        .rs(rs),
        .rt(rt),
        .illegal_write(illegal_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        core_state = S_IDLE;
        we         = 1'b0;
        mux        = 2'b00;
        rd_a       = 4'd0;
    endtask

    task automatic do_write(input logic [3:0] rd, input logic [1:0] m, input logic [7:0] im);
        core_state = S_UPDATE;
        we         = 1'b1;
        rd_a       = rd;
        mux        = m;
        imm        = im;
        tick();
        idle_inputs();
    endtask

    // Queue the expected operands, run REQUEST, then compare during WAIT.
    task automatic do_read(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [DB-1:0] ea, input logic [DB-1:0] eb);
        exp_t e;
        core_state = S_REQUEST;
        rs_a = a;
        rt_a = b;
        e.tag = {tag, ".rs"}; e.val = ea; sb.push_back(e);
        e.tag = {tag, ".rt"}; e.val = eb; sb.push_back(e);
        tick();
        core_state = S_WAIT;
        rs_a = 4'd0;
        rt_a = 4'd0;
        e = sb.pop_front(); chk(e.tag, rs, e.val);
        e = sb.pop_front(); chk(e.tag, rt, e.val);
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        block_id = 8'd0;
        rs_a     = 4'd0;
        rt_a     = 4'd0;
        imm      = 8'd0;
        alu_out  = '0;
        lsu_out  = '0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        chk("rst.rs", rs, 8'h00);
        chk("rst.rt", rt, 8'h00);
        chk("rst.illegal", {7'd0, illegal_write}, 8'h00);
        reset = 1'b1;
        do_read("rst_rd", 4'd3, 4'd15, 8'h00, 8'(TID));
        chk("rst_rd.illegal", {7'd0, illegal_write}, 8'h00);

        // Immediate write, readback with blockDim
        do_write(4'd5, 2'b10, 8'hA7);
        do_read("imm", 4'd5, 4'd14, 8'hA7, 8'(TPB));

        // Operand hold through EXECUTE/UPDATE with no write enable
        core_state = S_EXECUTE;
        tick();
        chk("hold.rs", rs, 8'hA7);
        core_state = S_UPDATE;
        tick();
        chk("hold.rt", rt, 8'(TPB));
        idle_inputs();

        // Source mux
        alu_out = 8'h3C;
        lsu_out = 8'h81;
        do_write(4'd1, 2'b00, 8'hEE);
        do_write(4'd2, 2'b01, 8'hEE);
        do_read("mux", 4'd1, 4'd2, 8'h3C, 8'h81);

        // Write enable outside UPDATE is ignored
        core_state = S_EXECUTE;
        we   = 1'b1;
        rd_a = 4'd1;
        mux  = 2'b10;
        imm  = 8'hFF;
        tick();
        idle_inputs();
        do_read("exec_we", 4'd1, 4'd2, 8'h3C, 8'h81);
        chk("exec_we.illegal", {7'd0, illegal_write}, 8'h00);

        // Protected destination
        do_write(4'd14, 2'b10, 8'h55);
        chk("prot.illegal", {7'd0, illegal_write}, 8'h01);
        do_read("prot", 4'd14, 4'd0, 8'(TPB), 8'h00);

        // Reserved source: no write to R0, flag stays set
        do_write(4'd0, 2'b11, 8'h66);
        do_read("mux11", 4'd0, 4'd15, 8'h00, 8'(TID));
        chk("mux11.illegal", {7'd0, illegal_write}, 8'h01);

        // Enable gating: R13, operands and writeback frozen
        enable   = 1'b0;
        block_id = 8'd7;
        tick();
        tick();
        tick();
        do_write(4'd4, 2'b10, 8'h99);
        core_state = S_REQUEST;
        rs_a = 4'd5;
        rt_a = 4'd5;
        tick();
        chk("dis.rs", rs, 8'h00);
        chk("dis.rt", rt, 8'(TID));
        idle_inputs();
        enable = 1'b1;
        // First enabled cycle still sees the old R13
        do_read("r13_lag", 4'd13, 4'd5, 8'h00, 8'hA7);
        do_read("r13", 4'd13, 4'd4, 8'h07, 8'h00);

        // Reset in the middle of an UPDATE
        do_read("pre_rst", 4'd5, 4'd14, 8'hA7, 8'(TPB));
        core_state = S_UPDATE;
        we    = 1'b1;
        rd_a  = 4'd6;
        mux   = 2'b10;
        imm   = 8'h12;
        reset = 1'b0;
        tick();
        chk("midrst.rs", rs, 8'h00);
        chk("midrst.rt", rt, 8'h00);
        chk("midrst.illegal", {7'd0, illegal_write}, 8'h00);
        reset = 1'b1;
        idle_inputs();
        do_read("midrst_rd", 4'd6, 4'd13, 8'h00, 8'h00);
        do_read("post_rst", 4'd13, 4'd5, 8'h07, 8'h00);

        chk("sb.empty", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file for the compute core: one instance per thread lane, sitting directly upstream and downstream of that lane's ALU. It supplies the two source operands (rs, rt) during the REQUEST phase. It commits the ALU result, load result or decoded immediate to the destination register during the UPDATE phase. Registers R13–R15 expose block index, block size and thread index to software as read-only values.

## Interface
- THREADS_PER_BLOCK, 4: value presented as R14 (blockDim).
- THREAD_ID, 0: this lane's index, presented as R15 (threadIdx).
- DATA_BITS, 8: register and operand width.
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- enable  input  1  lane active; low = lane idle, all state frozen.
- block_id  input  8  index of the block currently dispatched to the core.
- core_state  input  3  core phase: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- decoded_rd_address  input  4  destination register.
- decoded_rs_address  input  4  source register 1.
- decoded_rt_address  input  4  source register 2.
- decoded_reg_write_enable  input  1  instruction writes rd.
- decoded_reg_input_mux  input  2  writeback source: 00 = alu_out, 01 = lsu_out, 10 = immediate, 11 = reserved.
- decoded_immediate  input  8  constant for CONST instructions.
- alu_out  input  DATA_BITS  result from this lane's ALU.
- lsu_out  input  DATA_BITS  load data from this lane's LSU.
- rs  output  DATA_BITS  registered operand 1, to ALU/LSU.
- rt  output  DATA_BITS  registered operand 2, to ALU/LSU.
- illegal_write  output  1  sticky flag, set by an attempted write to R13–R15.

## Operation
- Storage: R0–R12 are general-purpose flops of DATA_BITS each. R13 holds a block_id copy. R14 and R15 are constants equal to THREADS_PER_BLOCK and THREAD_ID.
- Everything below applies only on cycles with reset high and enable high. With enable low, no register, output or flag changes.
- R13 update: R13 <= block_id on every enabled cycle, independent of core_state.
- Operand read (core_state == REQUEST): rs <= R[decoded_rs_address] and rt <= R[decoded_rt_address]. In all other states rs and rt hold their values.
- Writeback (core_state == UPDATE and decoded_reg_write_enable == 1):
  - rd 0–12: R[rd] <= selected source.
  - Source select: mux 00 -> alu_out, 01 -> lsu_out, 10 -> decoded_immediate. The immediate is zero-extended or truncated to DATA_BITS.
  - Mux 11: no write, and illegal_write is set.
  - rd 13–15: no write, and illegal_write is set.
- Writeback does nothing when write enable is low or the state is not UPDATE.
- illegal_write clears only on reset.
- Read addresses 13–15 return the live R13 value or the constants.
- No bypass is needed: REQUEST and UPDATE never occur in the same cycle.

## Timing
- Reset (reset == 0 at a rising edge):
  - R0–R12 = 0.
  - R13 = 0.
  - rs = 0, rt = 0.
  - illegal_write = 0.
- Reset takes priority over enable and over any state, including mid-UPDATE; the pending write is dropped.
- Operand latency: rs and rt are valid one cycle after the REQUEST cycle, i.e. during WAIT and EXECUTE, and hold through UPDATE.
- Writeback latency: the destination is updated on the edge ending the UPDATE cycle. A read in the next instruction's REQUEST sees the new value.
- R13 lags block_id by one enabled cycle.
- Results wrap modulo 2^DATA_BITS, because sources arrive already DATA_BITS wide.

## Test plan
- Reset: drive reset = 0 for 2 cycles, then REQUEST with rs = R3 and rt = R15 (THREAD_ID = 2) -> rs = 0, rt = 2, illegal_write = 0.
- Immediate write and readback: UPDATE with rd = 5, mux = 10, imm = 0xA7, write enable = 1; then REQUEST with rs = R5, rt = R14 -> rs = 0xA7, rt = THREADS_PER_BLOCK (4).
- Source mux: with alu_out = 0x3C and lsu_out = 0x81, UPDATE rd = 1 with mux 00, then UPDATE rd = 2 with mux 01 -> R1 = 0x3C, R2 = 0x81. Also apply write enable = 1 in EXECUTE (not UPDATE) -> no change.
- Protected registers: UPDATE rd = 14, mux = 10, imm = 0x55 -> R14 still reads 4, illegal_write = 1 and stays 1. A later mux = 11 write to rd = 0 leaves R0 unchanged.
- Enable gating and R13: set block_id = 7 with enable = 0 for 3 cycles -> R13 reads 0. Raise enable, wait 1 cycle, then REQUEST rs = R13 -> rs = 7. Also apply an UPDATE to rd = 4 while enable = 0 -> R4 unchanged.
- Reset mid-operation: assert reset = 0 in the UPDATE cycle of a write rd = 6, imm = 0x12 -> R6 = 0, and rs/rt cleared on the following cycle.
